// File: rtl/seg_display_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared types and seven-segment constants for seg_display_sched.
// Revision : 1.0
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic       c_src_cpu    = 1'b0;
    localparam logic       c_src_dbg    = 1'b1;
    localparam logic [6:0] c_seg_blank  = 7'h7F;
    localparam logic [6:0] c_seg_broken = 7'b1110111;
    localparam logic [7:0] c_an_off     = 8'hFF;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = c_seg_broken;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_sched_bcd_iter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_iter
// Brief    : Iterative double-dabble binary-to-BCD engine, one bit per cycle.
// Revision : 1.0
// ============================================================================
module bcd_iter
    import seg_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      data,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic [BCD_W-1:0] w_adj;
    logic             w_last;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
            assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                     (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
        end
    endgenerate

    // High during the cycle whose closing edge performs the final shift
    assign w_last = r_active && (r_cnt == CNT_W'(BIN_W - 1));
    assign done   = w_last;
    assign bcd    = r_bcd;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_bin    <= data;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_sched.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_sched
// Brief    : Two-source arbiter, BCD conversion and 8-slot multiplexed
//            seven-segment scan. Option macro: SEG_LEADING_BLANK_EN.
// Revision : 1.0
// ============================================================================
module seg_display_sched
    import seg_pkg::*;
#(
    parameter int BIN_W   = 16,
    parameter int DIGITS  = 5,
    parameter int CLK_DIV = 100000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [BIN_W-1:0]  req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [BIN_W-1:0]  req1_data,
    output logic              req1_ready,
    output logic              busy,
    output logic              done,
    output logic              shown_src,
    output logic [7:0]        AN,
    output logic [6:0]        SEG
);

    localparam int         PRESC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int         BCD_W    = 4 * DIGITS;
    localparam logic [3:0] c_digits = 4'(DIGITS);

    state_t             r_state;
    state_t             w_next;
    logic               r_last_grant;
    logic               r_pend_src;
    logic [BCD_W-1:0]   r_display;
    logic               r_done;
    logic               r_shown;
    logic [PRESC_W-1:0] r_presc;
    logic [2:0]         r_slot;
    logic [7:0]         r_an;
    logic [6:0]         r_seg;

    logic               w_idle;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;
    logic [BIN_W-1:0]   w_start_data;
    logic               w_bcd_done;
    logic [BCD_W-1:0]   w_bcd;
    logic [31:0]        w_disp8;
    logic [3:0]         w_nib;
    logic               w_slot_on;

    // Ties go to whichever source did not win the previous grant
    assign w_idle       = (r_state == IDLE);
    assign w_grant0     = req0_valid && (!req1_valid || (r_last_grant == c_src_dbg));
    assign w_grant1     = req1_valid && (!req0_valid || (r_last_grant == c_src_cpu));
    assign req0_ready   = w_idle && w_grant0;
    assign req1_ready   = w_idle && w_grant1;
    assign w_accept     = req0_ready || req1_ready;
    assign w_start_data = w_grant1 ? req1_data : req0_data;

    bcd_iter #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bcd_iter (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (w_accept),
        .data    (w_start_data),
        .done    (w_bcd_done),
        .bcd     (w_bcd)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next = CONVERT;
            CONVERT: if (w_bcd_done) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= c_src_dbg;
            r_pend_src   <= c_src_cpu;
            r_display    <= '0;
            r_done       <= 1'b0;
            r_shown      <= c_src_cpu;
        end else begin
            r_done <= (r_state == COMMIT);
            if (w_accept) begin
                r_last_grant <= w_grant1;
                r_pend_src   <= w_grant1;
            end
            if (r_state == COMMIT) begin
                r_display <= w_bcd;
                r_shown   <= r_pend_src;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_slot  <= 3'd0;
        end else if (r_presc == PRESC_W'(CLK_DIV - 1)) begin
            r_presc <= '0;
            r_slot  <= r_slot + 3'd1;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Zero-extend to eight nibbles so unused slots index safely
    always_comb begin
        w_disp8             = '0;
        w_disp8[BCD_W-1:0]  = r_display;
    end
    assign w_nib = w_disp8[{r_slot, 2'b00} +: 4];

`ifdef SEG_LEADING_BLANK_EN
    logic [2:0] w_msd;

    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_display[4*i +: 4] != 4'd0) begin
                w_msd = 3'(i);
            end
        end
    end

    assign w_slot_on = ({1'b0, r_slot} < c_digits) && (r_slot <= w_msd);
`else
    assign w_slot_on = ({1'b0, r_slot} < c_digits);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_an  <= c_an_off;
            r_seg <= c_seg_blank;
        end else begin
            r_an  <= w_slot_on ? ~(8'd1 << r_slot) : c_an_off;
            r_seg <= w_slot_on ? seg_encode(w_nib) : c_seg_blank;
        end
    end

    assign busy      = !w_idle;
    assign done      = r_done;
    assign shown_src = r_shown;
    assign AN        = r_an;
    assign SEG       = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_sched
// Brief    : Scoreboard bench for seg_display_sched (CLK_DIV = 4).
// Revision : 1.0
// ============================================================================
module tb_seg_display_sched;

    localparam int BIN_W   = 16;
    localparam int DIGITS  = 5;
    localparam int CLK_DIV = 4;

    logic             clock      = 1'b0;
    logic             reset_n    = 1'b0;
    logic             req0_valid = 1'b0;
    logic [BIN_W-1:0] req0_data  = '0;
    logic             req1_valid = 1'b0;
    logic [BIN_W-1:0] req1_data  = '0;
    logic             req0_ready;
    logic             req1_ready;
    logic             busy;
    logic             done;
    logic             shown_src;
    logic [7:0]       AN;
    logic [6:0]       SEG;

    typedef struct {
        int   value;
        logic src;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] cap_an[32];
    logic [6:0] cap_seg[32];
    int         cap_slot[32];

    seg_display_sched #(
        .BIN_W   (BIN_W),
        .DIGITS  (DIGITS),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .busy       (busy),
        .done       (done),
        .shown_src  (shown_src),
        .AN         (AN),
        .SEG        (SEG)
    );

    always #5 clock = ~clock;

    // Edges since reset release; outputs after edge k show slot ((k-1)/CLK_DIV)%8
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic int pow10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] model_digit(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1110111;
        endcase
    endfunction

    function automatic bit model_on(input int value, input int slot);
        if (slot >= DIGITS) return 1'b0;
`ifdef SEG_LEADING_BLANK_EN
        if (slot > 0 && value < pow10(slot)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [7:0] model_an(input int value, input int slot);
        return model_on(value, slot) ? ~(8'd1 << slot) : 8'hFF;
    endfunction

    function automatic logic [6:0] model_seg(input int value, input int slot);
        return model_on(value, slot) ? model_digit((value / pow10(slot)) % 10) : 7'h7F;
    endfunction

    task automatic capture_frame();
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            #1;
            cap_an[i]   = AN;
            cap_seg[i]  = SEG;
            cap_slot[i] = ((cyc - 1) / CLK_DIV) % 8;
        end
    endtask

    task automatic wait_done(output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic send(input bit src, input int value, output int acc, output bit ok);
        @(negedge clock);
        if (src) begin req1_valid = 1'b1; req1_data = value[BIN_W-1:0]; end
        else     begin req0_valid = 1'b1; req0_data = value[BIN_W-1:0]; end
        ok  = 1'b0;
        acc = -1;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if ((src ? req1_ready : req0_ready) === 1'b1) begin
                ok  = 1'b1;
                acc = cyc + 1;
                sb.push_back('{value, src});
            end
            @(negedge clock);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (AN !== 8'hFF || SEG !== 7'h7F) begin
            errors++;
            $display("FAIL reset_outputs: AN=%h SEG=%b, required AN=ff SEG=1111111", AN, SEG);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || shown_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b shown_src=%b, required 0 0 0", busy, done, shown_src);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (AN !== 8'b11111110 || SEG !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_first_slot: AN=%b SEG=%b, required AN=11111110 SEG=1000000", AN, SEG);
        end
    endtask

    task automatic test_scan();
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (cap_an[i] !== model_an(0, cap_slot[i]) || cap_seg[i] !== model_seg(0, cap_slot[i])) begin
                    errors++;
                    $display("FAIL scan_slot%0d: AN=%b SEG=%b, required AN=%b SEG=%b", cap_slot[i],
                             cap_an[i], cap_seg[i], model_an(0, cap_slot[i]), model_seg(0, cap_slot[i]));
                end
            end
        end
    endtask

    task automatic test_single(input bit src, input int value);
        int   acc, at;
        bit   ok;
        exp_t e;
        send(src, value, acc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_%0d: ready never seen, required within 60 cycles", value);
        end
        wait_done(at, ok);
        checks++;
        if (!ok || at !== acc + 17) begin
            errors++;
            $display("FAIL latency_%0d: done at accept+%0d, required accept+17", value, at - acc);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (shown_src !== e.src) begin
                errors++;
                $display("FAIL shown_src_%0d: got %b, required %b", e.value, shown_src, e.src);
            end
            capture_frame();
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (cap_an[i] !== model_an(e.value, cap_slot[i]) ||
                    cap_seg[i] !== model_seg(e.value, cap_slot[i])) begin
                    errors++;
                    $display("FAIL frame_%0d_slot%0d: AN=%b SEG=%b, required AN=%b SEG=%b", e.value,
                             cap_slot[i], cap_an[i], cap_seg[i],
                             model_an(e.value, cap_slot[i]), model_seg(e.value, cap_slot[i]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   acc0, acc1, at;
        bit   ok, got1;
        exp_t e;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        sb.delete();
        @(negedge clock);
        req0_valid = 1'b1; req0_data = 16'd7;
        req1_valid = 1'b1; req1_data = 16'd9;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_tie: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
        end
        acc0 = cyc + 1;
        sb.push_back('{7, 1'b0});
        @(negedge clock);
        req0_valid = 1'b0;
        got1 = 1'b0;
        acc1 = -1;
        for (int i = 0; i < 60 && !got1; i++) begin
            #1;
            if (done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (shown_src !== e.src || cyc !== acc0 + 17) begin
                    errors++;
                    $display("FAIL done_7: src=%b at accept+%0d, required src=%b at accept+17",
                             shown_src, cyc - acc0, e.src);
                end
            end
            if (req1_ready === 1'b1) begin
                got1 = 1'b1;
                acc1 = cyc + 1;
                sb.push_back('{9, 1'b1});
            end
            @(negedge clock);
        end
        req1_valid = 1'b0;
        checks++;
        if (acc1 !== acc0 + 18) begin
            errors++;
            $display("FAIL second_accept: req1 accepted at +%0d, required +18", acc1 - acc0);
        end
        wait_done(at, ok);
        checks++;
        if (!ok || sb.size() != 1 || shown_src !== 1'b1 || at !== acc1 + 17) begin
            errors++;
            $display("FAIL done_9: ok=%b src=%b at +%0d, required ok=1 src=1 at +17", ok, shown_src, at - acc1);
        end
        if (sb.size() > 0) e = sb.pop_front();
        @(negedge clock);
        req0_valid = 1'b1; req0_data = 16'd8;
        req1_valid = 1'b1; req1_data = 16'd9;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL alternate_tie: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
        end
        sb.push_back('{8, 1'b0});
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done(at, ok);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (!ok || shown_src !== e.src) begin
                errors++;
                $display("FAIL done_8: ok=%b src=%b, required ok=1 src=%b", ok, shown_src, e.src);
            end
            capture_frame();
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (cap_an[i] !== model_an(e.value, cap_slot[i]) ||
                    cap_seg[i] !== model_seg(e.value, cap_slot[i])) begin
                    errors++;
                    $display("FAIL frame_8_slot%0d: AN=%b SEG=%b, required AN=%b SEG=%b", cap_slot[i],
                             cap_an[i], cap_seg[i], model_an(8, cap_slot[i]), model_seg(8, cap_slot[i]));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc, pulses;
        bit ok;
        send(1'b0, 999, acc, ok);
        repeat (8) @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (AN !== 8'hFF || SEG !== 7'h7F || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: AN=%h SEG=%b busy=%b done=%b, required ff 1111111 0 0",
                     AN, SEG, busy, done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midreset_done: %0d done pulses, required 0", pulses);
        end
        capture_frame();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_an[i] !== model_an(0, cap_slot[i]) || cap_seg[i] !== model_seg(0, cap_slot[i])) begin
                errors++;
                $display("FAIL midreset_frame_slot%0d: AN=%b SEG=%b, required AN=%b SEG=%b", cap_slot[i],
                         cap_an[i], cap_seg[i], model_an(0, cap_slot[i]), model_seg(0, cap_slot[i]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_single(1'b0, 1234);
        test_single(1'b1, 65535);
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_sched.md
# seg_display_sched

Display scheduler for the board's 8-digit seven-segment panel. It arbitrates two value sources (CPU register tap, debug port) for ownership of the display. It converts the granted binary value to BCD with an iterative double-dabble engine, then commits the result atomically to a display register. It continuously time-multiplexes the digits onto the shared active-low anode and segment lines.

## Interface
- `BIN_W`, 16: width of source values. Legal range 1..26.
- `DIGITS`, 5: digit slots used. Requires 10^DIGITS > 2^BIN_W−1 and DIGITS ≤ 8.
- `CLK_DIV`, 100000: clocks per digit slot (refresh prescaler). Must be ≥ 2.
- `clock` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: CPU source has a value.
- `req0_data` in BIN_W: CPU value.
- `req0_ready` out 1: CPU value accepted this cycle when both valid and ready are high.
- `req1_valid`, `req1_data`, `req1_ready`: same for the debug source.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse when the display register updates.
- `shown_src` out 1: source of the value currently displayed.
- `AN` out 8: anode enables, active-low, one-hot-low or all high.
- `SEG` out 7: segments {g..a}, active-low.

## Operation
- FSM states:
  - IDLE: ready is asserted toward the granted source only.
  - CONVERT: runs BIN_W iterations.
  - COMMIT: lasts 1 cycle, then returns to IDLE.
- Arbitration in IDLE, combinational:
  - One valid: that source is granted.
  - Both valid: the source not granted last time wins.
  - The last-grant pointer resets to "req1", so req0 wins the first tie.
  - Transfer occurs on valid && ready. Data is latched into the shift register and the source ID into a pending-source register.
- Source rules: a source must hold valid and data stable until ready. While the FSM is not in IDLE, both readys are low.
- CONVERT, per cycle:
  - Each BCD nibble ≥5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - The BCD register is 4·DIGITS bits wide.
  - An iteration counter of width clog2(BIN_W+1) counts 0..BIN_W−1.
- COMMIT: BCD result is copied to the display register, pending source to `shown_src`, and `done` pulses.
- Scan:
  - Prescaler counts 0..CLK_DIV−1. On wrap, slot index 0..7 increments and wraps 7→0.
  - The scan runs in every FSM state and always reads the display register, so the panel never shows a partial conversion.
  - Slot s < DIGITS: AN = ~(1<<s). SEG is the encoding of nibble s: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other nibble gives 1110111.
  - Slot s ≥ DIGITS: AN = 8'hFF, SEG = 7'h7F. All 8 slots are scanned so brightness is uniform.
- Reset, at any time including mid-CONVERT:
  - Values: state IDLE; display register 0; `shown_src` 0; prescaler 0; slot 0; `busy` 0; `done` 0; `AN` 8'hFF; `SEG` 7'h7F.
  - An in-flight conversion is discarded and no `done` is issued.

## Timing
- Accept at edge T0 → CONVERT during T0+1..T0+BIN_W → COMMIT edge T0+BIN_W+1. At that edge the display register updates and `done` is high for that one cycle.
- Next accept is possible at edge T0+BIN_W+2. Throughput is one value per BIN_W+2 cycles.
- `busy` is high from T0+1 through the COMMIT cycle.
- `AN`/`SEG` are registered, one cycle behind slot/display state. After reset release they first drive slot 0 one cycle later.
- Display slot changes every CLK_DIV cycles; a full frame is 8·CLK_DIV cycles.
- A new display value appears on a slot no earlier than the slot's next registered update after COMMIT.

## Configuration
- `SEG_LEADING_BLANK_EN`
  - Defined: slots above the most significant nonzero digit are blanked (AN high, SEG 7'h7F). Slot 0 is always shown, so value 0 shows a single "0".
  - Undefined: all DIGITS slots are shown, including leading zeros.

## Structure
- Package `seg_pkg`:
  - seven-segment encodings for 0–9;
  - blank (7'h7F) and broken (7'b1110111) patterns;
  - FSM state enum {IDLE, CONVERT, COMMIT};
  - source-ID constants.
- Sub-module `bcd_iter`:
  - owns the double-dabble shift/adjust datapath and iteration counter;
  - handshake: start in, data in, done out, bcd out.
- Top level holds the arbiter, FSM glue, display register and scan logic.

## Test plan
- Reset: hold `reset_n`=0 → `AN`=8'hFF, `SEG`=7'h7F, `busy`=0. Release with CLK_DIV=4 → slot 0 shows 1000000 with AN=11111110.
- req0 = 16'd1234 → `done` at accept+17. Slots 0–3 show 4,3,2,1. Slot 4 is blank with `_EN`, "0" without. `shown_src`=0.
- req1 = 16'd65535 → slots 0–4 show 5,3,5,5,6. `shown_src`=1.
- req0 and req1 both valid right after reset, values 7 and 9 → 7 accepted first, 9 accepted at +18. Then with req0=8 and req1=9 both valid, req0 wins (alternation).
- Reset asserted 8 cycles into a conversion of 16'd999 → all outputs return to reset values immediately, no `done` pulse, and the display shows 0 after release.
- CLK_DIV=4 → AN low bit advances every 4 clocks, slot 7 wraps to slot 0, and slots 5–7 are always blank.
